// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares the unified memory port between instruction
// fetch (0), load/store unit (1) and matrix unit (2). One transaction is in
// flight at a time. A request/grant handshake is followed by a response, and
// a watchdog answers with an error if memory never responds.
//
// Build option MEM_ARB_RR_EN:
//   defined   -> round-robin, search starts after the most recent winner
//   undefined -> fixed priority LSU > MX > IF
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  // instruction fetch
  input  logic                if_req,
  input  logic                if_we,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [DATA_W-1:0]   if_wdata,
  input  logic [DATA_W/8-1:0] if_be,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // load/store unit
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  // matrix unit
  input  logic                mx_req,
  input  logic                mx_we,
  input  logic [ADDR_W-1:0]   mx_addr,
  input  logic [DATA_W-1:0]   mx_wdata,
  input  logic [DATA_W/8-1:0] mx_be,
  output logic                mx_gnt,
  output logic                mx_rvalid,
  output logic [DATA_W-1:0]   mx_rdata,
  output logic                mx_err,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [1:0]          owner_r;
  logic [1:0]          last_r;
  logic [7:0]          timer_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BE_W-1:0]     be_r;

  logic [2:0]          req_s;
  logic                any_req_s;
  logic [1:0]          winner_s;
  logic                capture_s;
  logic                gnt_hit_s;
  logic                resp_s;
  logic                timeout_s;
  logic [2:0]          owner_oh_s;
  logic [2:0]          gnt_vec_s;
  logic [2:0]          rvalid_vec_s;
  logic [2:0]          err_vec_s;
  logic [DATA_W-1:0]   resp_data_s;

  // Winner selection. With nobody requesting the result is the previous
  // winner; the caller only uses it when at least one request is present.
  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] result;
`ifdef MEM_ARB_RR_EN
    logic [1:0] cand;
    logic       found;
    result = last;
    found  = 1'b0;
    cand   = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[cand]) begin
        result = cand;
        found  = 1'b1;
      end else begin
        found  = found;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
`else
    if (req[1]) begin
      result = 2'd1;
    end else if (req[2]) begin
      result = 2'd2;
    end else if (req[0]) begin
      result = 2'd0;
    end else begin
      result = last;
    end
`endif
    return result;
  endfunction

  // Requester index to one-hot strobe mask.
  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  assign req_s     = {mx_req, lsu_req, if_req};
  assign any_req_s = |req_s;
  assign winner_s  = pick_winner(req_s, last_r);

  // Next-state logic plus the handshake events of the current cycle.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    gnt_hit_s   = 1'b0;
    resp_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          state_nxt_s = ST_WAIT;
          gnt_hit_s   = 1'b1;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A real response in the last watchdog cycle still wins.
        if (mem_rvalid) begin
          resp_s = 1'b1;
        end else if (timer_r == TIMER_LAST) begin
          resp_s    = 1'b1;
          timeout_s = 1'b1;
        end else begin
          resp_s = 1'b0;
        end
        if (resp_s && any_req_s) begin
          state_nxt_s = ST_ISSUE;
          capture_s   = 1'b1;
        end else if (resp_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, round-robin pointer, watchdog timer and captured payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      owner_r <= 2'd0;
      last_r  <= 2'd2;
      timer_r <= 8'd0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WAIT && !resp_s) begin
        timer_r <= timer_r + 8'd1;
      end else begin
        timer_r <= 8'd0;
      end
      if (capture_s) begin
        owner_r <= winner_s;
        last_r  <= winner_s;
        case (winner_s)
          2'd0: begin
            we_r <= if_we;  addr_r <= if_addr;  wdata_r <= if_wdata;  be_r <= if_be;
          end
          2'd1: begin
            we_r <= lsu_we; addr_r <= lsu_addr; wdata_r <= lsu_wdata; be_r <= lsu_be;
          end
          2'd2: begin
            we_r <= mx_we;  addr_r <= mx_addr;  wdata_r <= mx_wdata;  be_r <= mx_be;
          end
          default: begin
            we_r <= we_r;   addr_r <= addr_r;   wdata_r <= wdata_r;   be_r <= be_r;
          end
        endcase
      end else begin
        owner_r <= owner_r;
        last_r  <= last_r;
      end
    end
  end

  // Memory side is driven straight from the captured transaction.
  assign mem_req   = (state_r == ST_ISSUE);
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_be    = be_r;

  // Requester strobes go only to the current owner.
  assign owner_oh_s   = to_onehot(owner_r);
  assign gnt_vec_s    = gnt_hit_s ? owner_oh_s : 3'b000;
  assign rvalid_vec_s = resp_s    ? owner_oh_s : 3'b000;
  assign err_vec_s    = timeout_s ? owner_oh_s : 3'b000;
  assign resp_data_s  = timeout_s ? ERR_DATA : mem_rdata;

  assign if_gnt     = gnt_vec_s[0];
  assign lsu_gnt    = gnt_vec_s[1];
  assign mx_gnt     = gnt_vec_s[2];
  assign if_rvalid  = rvalid_vec_s[0];
  assign lsu_rvalid = rvalid_vec_s[1];
  assign mx_rvalid  = rvalid_vec_s[2];
  assign if_err     = err_vec_s[0];
  assign lsu_err    = err_vec_s[1];
  assign mx_err     = err_vec_s[2];
  assign if_rdata   = rvalid_vec_s[0] ? resp_data_s : {DATA_W{1'b0}};
  assign lsu_rdata  = rvalid_vec_s[1] ? resp_data_s : {DATA_W{1'b0}};
  assign mx_rdata   = rvalid_vec_s[2] ? resp_data_s : {DATA_W{1'b0}};

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Three-requester arbiter sharing the single unified memory port between instruction fetch (IF), load/store unit (LSU) and the matrix unit (MX) inside `riscv_top`. It runs one transaction at a time using a request/grant plus response handshake. Arbitration is round-robin or fixed-priority, selected at compile time. A watchdog terminates a response that never arrives.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` wide.
- `TIMEOUT`, 255, maximum cycles in WAIT before an error response (1..255).

Ports (`x` ∈ {`if`, `lsu`, `mx`}, requester index 0/1/2):
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `x_req`  in  1  request; held high with stable payload until `x_gnt`.
- `x_we`  in  1  1 = write, 0 = read.
- `x_addr`  in  ADDR_W  address.
- `x_wdata`  in  DATA_W  write data.
- `x_be`  in  DATA_W/8  byte enables.
- `x_gnt`  out  1  one-cycle pulse: memory accepted this requester's transaction.
- `x_rvalid`  out  1  one-cycle pulse: response (read data or write ack) for this requester.
- `x_rdata`  out  DATA_W  response data; valid only with `x_rvalid`.
- `x_err`  out  1  one-cycle pulse with `x_rvalid` when the response is a timeout.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  request to memory.
- `mem_gnt`  in  1  memory accepts `mem_req` this cycle.
- `mem_rvalid`  in  1  memory response; exactly one per accepted request.
- `mem_rdata`  in  DATA_W  response data.

## Operation
- FSM states:
  - IDLE: no transaction. If any `x_req` is high, pick a winner, register owner, `we`, `addr`, `wdata`, `be`; next state ISSUE.
  - ISSUE: `mem_req`=1 driving the registered payload. On `mem_gnt`, the owner's `x_gnt` pulses combinationally in the same cycle; next state WAIT, timer cleared.
  - WAIT: timer increments each cycle. On `mem_rvalid`, the owner receives `x_rvalid`=1 and `x_rdata`=`mem_rdata`, and the arbiter re-arbitrates in the same cycle: any request pending → ISSUE with a new winner, else → IDLE.
  - WAIT timeout: if the timer reaches `TIMEOUT` without `mem_rvalid`, the owner receives `x_rvalid`=1, `x_err`=1 and `x_rdata`=32'hDEAD_BEEF, then behaves exactly as the `mem_rvalid` exit. A late `mem_rvalid` for that transaction is dropped while in IDLE; the next memory response is assumed to belong to the new transaction.
- The round-robin pointer `last` records the most recent winner. It updates on entry to ISSUE.
- A requester that drops `x_req` before `x_gnt` is in protocol violation. The registered transaction still completes, and `x_gnt` and `x_rvalid` still pulse.
- Requester payload is captured only at arbitration; changes after capture are ignored.
- Non-owners never see `gnt`, `rvalid` or `err`. `x_rdata` may be broadcast but is meaningful only with `x_rvalid`.

## Timing
- Reset values: state IDLE, `last`=2 (MX), timer 0. All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, every `x_gnt`, `x_rvalid`, `x_err` and `x_rdata`.
- Latency: `x_req` high in cycle k while in IDLE → `mem_req` high in cycle k+1. Earliest `x_gnt` is k+1; earliest `x_rvalid` is k+2.
- Back-to-back: a request pending in the `mem_rvalid` cycle gets `mem_req` in the next cycle, with no IDLE bubble.
- `mem_req` stays high and the payload stays stable through ISSUE until `mem_gnt`. There is no timeout in ISSUE.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops any outstanding transaction. No `gnt`, `rvalid` or `err` is issued for it.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. Priority starts at `(last+1) mod 3` in the order IF(0) → LSU(1) → MX(2).
- Not defined: fixed priority LSU > MX > IF. `last` is still maintained but unused.

## Test plan
- Single read: `if_req`, addr 0x100; memory grants in the same cycle and returns 0x12345678 two cycles later → `if_gnt` at k+1, `if_rvalid` with 0x12345678. No LSU/MX strobes.
- Contention, RR (`MEM_ARB_RR_EN`): all three requesters hold `req` for 4 transactions → grant order IF, LSU, MX, IF. `mem_req` is gapless between transactions.
- Contention, fixed (macro undefined): IF and LSU request continuously → LSU wins every time until it drops `req`, then IF wins.
- Write ack: `lsu_we`=1, addr 0x2000, be 4'b0011 → `mem_we`=1, `mem_be`=4'b0011, `mem_addr`=0x2000. `lsu_rvalid` pulses on `mem_rvalid`.
- Timeout: `TIMEOUT`=8 and memory never responds → 8 cycles after `mx_gnt`, `mx_rvalid`=1, `mx_err`=1, `mx_rdata`=32'hDEAD_BEEF, then IDLE.
- Reset in WAIT: assert `reset_n`=0 mid-WAIT → outputs 0 asynchronously. After release, a new IF request is granted first (since `last`=MX).
